// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default constants and divisor clamp for
// the UART baud tick source. Build option BAUD_AUTOBAUD_EN adds the two
// autobaud states to the state enum.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_DIV = 651;
  localparam int unsigned UART_OSR         = 16;

`ifdef BAUD_AUTOBAUD_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PENDING = 3'd2,
    ST_AB_WAIT = 3'd3,
    ST_AB_MEAS = 3'd4
  } baud_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } baud_state_e;
`endif

  // A divisor of 0 or 1 cannot make a distinct one-cycle tick; force it to 2.
  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < 2) ? 2 : div;
  endfunction

endpackage

// File: rtl/autobaud_meter.sv
// autobaud_meter: synchronizes rx, detects its edges, times the low phase of
// a start bit with a saturating counter and rounds it to a divisor in clocks
// per oversample tick. Only built when BAUD_AUTOBAUD_EN is defined.
module autobaud_meter
  import uart_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned OSR = UART_OSR
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic         rx,
  input  logic         measure,
  output logic         fall,
  output logic         done,
  output logic         error,
  output logic [N-1:0] result
);

  localparam int unsigned OSW = $clog2(OSR);
  localparam int unsigned CW  = N + OSW;
  localparam int unsigned WW  = CW + 1;
  localparam int unsigned RW  = N + 1;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;
  logic          sat;
  logic [WW-1:0] width;
  logic [RW-1:0] rounded;
  logic          in_range;

  // Round a width in clocks to the nearest whole number of clocks per tick.
  function automatic logic [RW-1:0] round_div(input logic [WW-1:0] w);
    logic [WW-1:0] sum;
    sum = w + WW'(OSR / 2);
    return RW'(sum >> OSW);
  endfunction

  assign fall = rx_prev_q & ~rx_sync_q;
  assign rise = ~rx_prev_q & rx_sync_q;
  assign sat  = &cnt_q;

  // The falling edge is detected on a low cycle that is not counted here,
  // so the measured width is one more than the counter value.
  assign width    = {1'b0, cnt_q} + WW'(1);
  assign rounded  = round_div(width);
  assign in_range = (rounded >= RW'(2)) && !rounded[N];
  assign result   = rounded[N-1:0];
  assign done     = measure && rise && !sat && in_range;
  assign error    = measure && (sat || (rise && !in_range));

  // Synchronizer shift and measure counter, which clears outside a measurement.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    cnt_d     = '0;
    if (measure) begin
      cnt_d = cnt_q;
      if (!rx_sync_q && !sat) cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer idles high so a quiet line shows no edge out of reset.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_rate_controller.sv
// baud_rate_controller: programmable oversample tick and bit tick source.
// A new divisor written while running waits for the next bit boundary.
// Build option BAUD_AUTOBAUD_EN compiles in the autobaud measurement path.
module baud_rate_controller
  import uart_pkg::*;
#(
  parameter int unsigned N           = 16,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int unsigned OSR         = UART_OSR
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_div,
  output logic         cfg_ready,
  output logic [N-1:0] active_div,
  output logic         tick,
  output logic         bit_tick,
  input  logic         rx,
  input  logic         ab_start,
  output logic         ab_done,
  output logic         ab_error
);

  localparam int unsigned OSW = $clog2(OSR);

  baud_state_e    state_q, state_d;
  logic [N-1:0]   div_cnt_q, div_cnt_d;
  logic [OSW-1:0] os_cnt_q, os_cnt_d;
  logic [N-1:0]   active_div_q, active_div_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           cfg_xfer;
  logic [N-1:0]   cfg_div_clamped;

  assign tick = ((state_q == ST_RUN) || (state_q == ST_PENDING)) &&
                (div_cnt_q == active_div_q - N'(1));
  assign bit_tick        = tick && (&os_cnt_q);
  assign cfg_ready       = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cfg_xfer        = cfg_valid && cfg_ready;
  assign cfg_div_clamped = N'(clamp_div(32'(cfg_div)));
  assign active_div      = active_div_q;

`ifdef BAUD_AUTOBAUD_EN
  logic         ab_fall, ab_ok, ab_bad;
  logic [N-1:0] ab_result;
  logic         ab_done_q, ab_done_d, ab_error_q, ab_error_d;

  autobaud_meter #(.N(N), .OSR(OSR)) u_meter (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rx         (rx),
    .measure    (state_q == ST_AB_MEAS),
    .fall       (ab_fall),
    .done       (ab_ok),
    .error      (ab_bad),
    .result     (ab_result)
  );

  assign ab_done  = ab_done_q;
  assign ab_error = ab_error_q;
`else
  logic unused_ab_inputs;
  assign unused_ab_inputs = rx ^ ab_start;
  assign ab_done  = 1'b0;
  assign ab_error = 1'b0;
`endif

  // Next state, counters and divisor registers; counters free-run by default.
  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pending_d    = pending_q;
    div_cnt_d    = div_cnt_q + N'(1);
    os_cnt_d     = os_cnt_q;
    if (tick) begin
      div_cnt_d = '0;
      os_cnt_d  = os_cnt_q + OSW'(1);
    end
`ifdef BAUD_AUTOBAUD_EN
    ab_done_d  = 1'b0;
    ab_error_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        os_cnt_d  = '0;
        if (cfg_xfer) active_div_d = cfg_div_clamped;
        if (enable) state_d = ST_RUN;
`ifdef BAUD_AUTOBAUD_EN
        if (ab_start && !cfg_xfer) state_d = ST_AB_WAIT;
`endif
      end
      ST_RUN: begin
        if (cfg_xfer) begin
          if (enable) begin
            pending_d = cfg_div_clamped;
            state_d   = ST_PENDING;
          end else begin
            active_div_d = cfg_div_clamped;
            state_d      = ST_IDLE;
            div_cnt_d    = '0;
            os_cnt_d     = '0;
          end
        end
`ifdef BAUD_AUTOBAUD_EN
        else if (ab_start) begin
          state_d   = ST_AB_WAIT;
          div_cnt_d = '0;
          os_cnt_d  = '0;
        end
`endif
        else if (!enable) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          os_cnt_d  = '0;
        end
      end
      ST_PENDING: begin
        if (!enable || bit_tick) begin
          active_div_d = pending_q;
          state_d      = enable ? ST_RUN : ST_IDLE;
          div_cnt_d    = '0;
          os_cnt_d     = '0;
        end
      end
`ifdef BAUD_AUTOBAUD_EN
      ST_AB_WAIT: begin
        div_cnt_d = '0;
        os_cnt_d  = '0;
        if (ab_fall) state_d = ST_AB_MEAS;
      end
      ST_AB_MEAS: begin
        div_cnt_d = '0;
        os_cnt_d  = '0;
        if (ab_ok || ab_bad) begin
          state_d    = enable ? ST_RUN : ST_IDLE;
          ab_done_d  = ab_ok;
          ab_error_d = ab_bad;
          if (ab_ok) active_div_d = ab_result;
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        os_cnt_d  = '0;
      end
    endcase
  end

  // State, counter and divisor registers; reset drops any pending divisor.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      active_div_q <= N'(DEFAULT_DIV);
      pending_q    <= N'(DEFAULT_DIV);
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      active_div_q <= active_div_d;
      pending_q    <= pending_d;
    end
  end

`ifdef BAUD_AUTOBAUD_EN
  // Registered autobaud result pulses, aligned with the active_div update.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ab_done_q  <= 1'b0;
      ab_error_q <= 1'b0;
    end else begin
      ab_done_q  <= ab_done_d;
      ab_error_q <= ab_error_d;
    end
  end
`endif

endmodule

// File: tb/tb_baud_rate_controller.sv
// tb_baud_rate_controller: randomized self-checking bench. Expected tick
// times come from plain arithmetic: with divisor d started at cycle c, ticks
// fall at c + k*d and bit ticks at c + k*OSR*d.
module tb_baud_rate_controller;

  localparam int N   = 16;
  localparam int DEF = 651;
  localparam int OSR = 16;

  logic         clk = 1'b0;
  logic         reset, enable, cfg_valid, ab_start, rx;
  logic [N-1:0] cfg_div;
  logic         cfg_ready, tick, bit_tick, ab_done, ab_error;
  logic [N-1:0] active_div;

  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int last_tick = 0;

  baud_rate_controller #(.N(N), .DEFAULT_DIV(DEF), .OSR(OSR)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .active_div (active_div),
    .tick       (tick),
    .bit_tick   (bit_tick),
    .rx         (rx),
    .ab_start   (ab_start),
    .ab_done    (ab_done),
    .ab_error   (ab_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_tick(input int budget, output int t, output logic bt, output bit ok);
    ok = 1'b0; t = -1; bt = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        t = cyc; bt = bit_tick; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic cfg_write(input logic [N-1:0] v);
    cfg_valid = 1'b1; cfg_div = v;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; ab_start = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    vectors++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL reset_bit_tick: got %b want 0", bit_tick); end
    vectors++; if (active_div !== N'(DEF)) begin errors++; $display("FAIL reset_active_div: got %0d want %0d", active_div, DEF); end
    vectors++; if (ab_done !== 1'b0) begin errors++; $display("FAIL reset_ab_done: got %b want 0", ab_done); end
    vectors++; if (ab_error !== 1'b0) begin errors++; $display("FAIL reset_ab_error: got %b want 0", ab_error); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_run();
    int c, t; logic bt; bit ok; logic exp_b;
    c = cyc; enable = 1'b1;
    for (int k = 1; k <= OSR + 1; k++) begin
      wait_tick(DEF + 5, t, bt, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL default_tick%0d: no tick observed, want cycle %0d", k, c + k*DEF); return; end
      if (t !== c + k*DEF) begin errors++; $display("FAIL default_tick%0d: at cycle %0d want %0d", k, t, c + k*DEF); end
      exp_b = (k % OSR == 0);
      vectors++; if (bt !== exp_b) begin errors++; $display("FAIL default_bit_tick%0d: got %b want %b", k, bt, exp_b); end
    end
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL default_cfg_ready: got %b want 1", cfg_ready); end
    last_tick = t;
  endtask

  task automatic test_switch_pending();
    int prev, t, n; logic bt; bit ok;
    repeat ($urandom_range(20, 300)) @(negedge clk);
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL switch_ready_before: got %b want 1", cfg_ready); end
    cfg_write(N'(27));
    vectors++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL switch_ready_pending: got %b want 0", cfg_ready); end
    n = OSR - ((OSR + 1) % OSR);
    prev = last_tick;
    for (int k = 1; k <= n; k++) begin
      wait_tick(DEF + 5, t, bt, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL switch_old_tick%0d: no tick observed, want cycle %0d", k, prev + DEF); return; end
      if (t !== prev + DEF) begin errors++; $display("FAIL switch_old_tick%0d: at cycle %0d want %0d", k, t, prev + DEF); end
      vectors++; if (bt !== (k == n)) begin errors++; $display("FAIL switch_bit_tick%0d: got %b want %b", k, bt, (k == n)); end
      vectors++; if (active_div !== N'(DEF)) begin errors++; $display("FAIL switch_old_div%0d: got %0d want %0d", k, active_div, DEF); end
      prev = t;
    end
    for (int k = 1; k <= 2; k++) begin
      wait_tick(40, t, bt, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL switch_new_tick%0d: no tick observed, want cycle %0d", k, prev + 27); return; end
      if (t !== prev + 27) begin errors++; $display("FAIL switch_new_tick%0d: at cycle %0d want %0d", k, t, prev + 27); end
      prev = t;
    end
    vectors++; if (active_div !== N'(27)) begin errors++; $display("FAIL switch_new_div: got %0d want 27", active_div); end
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL switch_ready_after: got %b want 1", cfg_ready); end
    last_tick = prev;
  endtask

  task automatic test_enable_drop_pending();
    int seen;
    cfg_valid = 1'b1; cfg_div = N'(100);
    @(negedge clk);
    cfg_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    vectors++; if (active_div !== N'(100)) begin errors++; $display("FAIL drop_active_div: got %0d want 100", active_div); end
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL drop_cfg_ready: got %b want 1", cfg_ready); end
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (tick === 1'b1) seen++;
    end
    vectors++; if (seen !== 0) begin errors++; $display("FAIL drop_quiet: %0d ticks seen want 0", seen); end
  endtask

  task automatic test_clamp_and_random();
    int v, d, c, seen; logic exp_t, exp_b;
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 0 : (i == 1) ? 1 : int'($urandom_range(2, 40));
      d = (v < 2) ? 2 : v;
      cfg_write(N'(v));
      vectors++; if (active_div !== N'(d)) begin errors++; $display("FAIL clamp_div w%0d: got %0d want %0d", v, active_div, d); end
      c = cyc; enable = 1'b1;
      for (int j = 1; j <= OSR*d + d; j++) begin
        @(negedge clk);
        exp_t = (j % d == 0);
        exp_b = (j % (OSR*d) == 0);
        vectors++;
        if (tick !== exp_t || bit_tick !== exp_b) begin
          errors++;
          $display("FAIL rand_div%0d cyc+%0d: tick=%b bit_tick=%b want %b %b", d, j, tick, bit_tick, exp_t, exp_b);
        end
      end
      enable = 1'b0;
      @(negedge clk);
      seen = 0;
      repeat (d + 3) begin
        @(negedge clk);
        if (tick === 1'b1) seen++;
      end
      vectors++; if (seen !== 0) begin errors++; $display("FAIL rand_idle_div%0d: %0d ticks want 0", d, seen); end
    end
  endtask

  task automatic test_reset_mid_pending();
    cfg_write(N'(20));
    enable = 1'b1;
    repeat (30) @(negedge clk);
    cfg_write(N'(50));
    vectors++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstpend_ready: got %b want 0", cfg_ready); end
    reset = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (active_div !== N'(DEF)) begin errors++; $display("FAIL rstpend_div: got %0d want %0d", active_div, DEF); end
    vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstpend_ready_after: got %b want 1", cfg_ready); end
    vectors++; if (tick !== 1'b0) begin errors++; $display("FAIL rstpend_tick: got %b want 0", tick); end
  endtask

`ifdef BAUD_AUTOBAUD_EN
  task automatic run_autobaud(input int low_w, input bit want_ok, input int want_div);
    int seen, td, t; logic bt; bit ok, got;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    ab_start = 1'b1;
    @(negedge clk);
    ab_start = 1'b0;
    repeat (3) @(negedge clk);
    seen = 0;
    rx = 1'b0;
    for (int i = 0; i < low_w; i++) begin
      @(negedge clk);
      if (tick === 1'b1 || ab_done === 1'b1 || ab_error === 1'b1) seen++;
    end
    rx = 1'b1;
    vectors++; if (seen !== 0) begin errors++; $display("FAIL ab%0d_quiet: %0d events during measure want 0", low_w, seen); end
    got = 1'b0; td = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ab_done === 1'b1 || ab_error === 1'b1) begin got = 1'b1; td = cyc; end
    end
    vectors++;
    if (!got) begin errors++; $display("FAIL ab%0d_result: no pulse within 10 cycles", low_w); return; end
    if (ab_done !== want_ok || ab_error !== !want_ok) begin
      errors++; $display("FAIL ab%0d_pulse: done=%b error=%b want %b %b", low_w, ab_done, ab_error, want_ok, !want_ok);
    end
    vectors++; if (active_div !== N'(want_div)) begin errors++; $display("FAIL ab%0d_div: got %0d want %0d", low_w, active_div, want_div); end
    @(negedge clk);
    vectors++; if (ab_done !== 1'b0 || ab_error !== 1'b0) begin errors++; $display("FAIL ab%0d_one_cycle: done=%b error=%b want 0 0", low_w, ab_done, ab_error); end
    for (int k = 1; k <= 2; k++) begin
      wait_tick(want_div + 5, t, bt, ok);
      vectors++;
      if (!ok || t !== td + k*want_div - 1) begin
        errors++; $display("FAIL ab%0d_tick%0d: at cycle %0d want %0d", low_w, k, t, td + k*want_div - 1);
      end
    end
  endtask

  task automatic test_autobaud();
    run_autobaud(1736, 1'b1, (1736 + OSR/2) / OSR);
    run_autobaud(16, 1'b0, (1736 + OSR/2) / OSR);
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`else
  task automatic test_autobaud();
    int c; logic exp_t, exp_b;
    cfg_write(N'(10));
    c = cyc; enable = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      ab_start = (j == 5);
      rx = !(j >= 20 && j < 220);
      @(negedge clk);
      exp_t = (j % 10 == 0);
      exp_b = (j % (OSR*10) == 0);
      vectors++;
      if (tick !== exp_t || bit_tick !== exp_b || ab_done !== 1'b0 || ab_error !== 1'b0) begin
        errors++;
        $display("FAIL noab cyc+%0d: tick=%b bit=%b done=%b err=%b want %b %b 0 0", j, tick, bit_tick, ab_done, ab_error, exp_t, exp_b);
      end
    end
    ab_start = 1'b0; rx = 1'b1;
    vectors++; if (active_div !== N'(10)) begin errors++; $display("FAIL noab_div: got %0d want 10", active_div); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_switch_pending();
    test_enable_drop_pending();
    test_clamp_and_random();
    test_reset_mid_pending();
    test_autobaud();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
